// File: rtl/coproc_pkg.sv
// Shared definitions for the image coprocessor: default frame geometry and
// the scan FSM state encoding.
package coproc_pkg;

    localparam int LARGURA_PAD = 160;
    localparam int ALTURA_PAD  = 120;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LER    = 3'd1;
    localparam logic [2:0] ST_ESPERA = 3'd2;
    localparam logic [2:0] ST_ENVIA  = 3'd3;
    localparam logic [2:0] ST_FIM    = 3'd4;

endpackage

// File: rtl/contador_xy.sv
// Raster-order x/y counters with a linear address that advances alongside
// them, so the read address never needs a y*LARGURA product.
module contador_xy #(
    parameter int LARGURA = 160,
    parameter int ALTURA  = 120,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              ultimo
);

    localparam logic [9:0] X_MAX = 10'(LARGURA - 1);
    localparam logic [9:0] Y_MAX = 10'(ALTURA - 1);

    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (inc) begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign addr   = addr_q;
    assign ultimo = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/varredura_origem.sv
// Scans one source frame in raster order: read, wait one cycle for the memory,
// then hand the pixel and its coordinates downstream with ready_in backpressure.
module varredura_origem
    import coproc_pkg::*;
#(
    parameter int LARGURA = LARGURA_PAD,
    parameter int ALTURA  = ALTURA_PAD,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        escala,
    input  logic [7:0]        mem_data,
    input  logic              ready_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        pixel_out,
    output logic [9:0]        x_orig,
    output logic [9:0]        y_orig,
    output logic [2:0]        escala_out,
    output logic              enable_out,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    logic [2:0]        state_q, state_d;
    logic [7:0]        pixel_q, pixel_d;
    logic [9:0]        xo_q, xo_d;
    logic [9:0]        yo_q, yo_d;
    logic [2:0]        escala_q, escala_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              erro_q, erro_d;

    logic              cnt_clear, cnt_inc, ultimo;
    logic [9:0]        x_cnt, y_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    contador_xy #(
        .LARGURA(LARGURA),
        .ALTURA (ALTURA),
        .ADDR_W (ADDR_W)
    ) u_contador (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .x     (x_cnt),
        .y     (y_cnt),
        .addr  (addr_cnt),
        .ultimo(ultimo)
    );

    always_comb begin
        state_d   = state_q;
        pixel_d   = pixel_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        escala_d  = escala_q;
        busy_d    = busy_q;
        erro_d    = erro_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (escala != 3'd0) begin
                        escala_d  = escala;
                        erro_d    = 1'b0;
                        busy_d    = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = ST_LER;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = ST_FIM;
                    end
                end
            end
            ST_LER:    state_d = ST_ESPERA;
            ST_ESPERA: begin
                // mem_data now answers the address presented during LER
                pixel_d = mem_data;
                xo_d    = x_cnt;
                yo_d    = y_cnt;
                state_d = ST_ENVIA;
            end
            ST_ENVIA: begin
                if (ready_in) begin
                    if (ultimo) begin
                        busy_d  = 1'b0;
                        state_d = ST_FIM;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = ST_LER;
                    end
                end
            end
            ST_FIM:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_FIM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pixel_q  <= '0;
            xo_q     <= '0;
            yo_q     <= '0;
            escala_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pixel_q  <= pixel_d;
            xo_q     <= xo_d;
            yo_q     <= yo_d;
            escala_q <= escala_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            erro_q   <= erro_d;
        end
    end

    assign mem_addr   = addr_cnt;
    assign pixel_out  = pixel_q;
    assign x_orig     = xo_q;
    assign y_orig     = yo_q;
    assign escala_out = escala_q;
    assign enable_out = (state_q == ST_ENVIA) && ready_in;
    assign busy       = busy_q;
    assign done       = done_q;
    assign erro       = erro_q;

endmodule

// File: tb/tb_varredura_origem.sv
// Bench for varredura_origem on a 4x3 frame: the expected pixel stream is the
// raster sequence k -> (k%L, k/L, k+0x10) from a registered memory model.
module tb_varredura_origem;

    localparam int L  = 4;
    localparam int A  = 3;
    localparam int AW = 15;
    localparam int N  = L * A;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    escala = 3'd0;
    logic [7:0]    mem_data = 8'd0;
    logic          ready_in = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    pixel_out;
    logic [9:0]    x_orig, y_orig;
    logic [2:0]    escala_out;
    logic          enable_out, busy, done, erro;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int pulses = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int erro_at_done = 0;

    varredura_origem #(.LARGURA(L), .ALTURA(A), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .escala(escala),
        .mem_data(mem_data), .ready_in(ready_in), .mem_addr(mem_addr),
        .pixel_out(pixel_out), .x_orig(x_orig), .y_orig(y_orig),
        .escala_out(escala_out), .enable_out(enable_out), .busy(busy),
        .done(done), .erro(erro)
    );

    always #5 clk = ~clk;

    // Source memory: synchronous read returning address + 0x10
    always @(posedge clk) mem_data <= mem_addr[7:0] + 8'h10;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the k-th transfer of a frame is raster pixel k
    always @(negedge clk) begin
        if (enable_out) begin
            $display("[TB] pixel %0d: x=%0d y=%0d data=%02h", pulses, x_orig, y_orig, pixel_out);
            chk("pulse_in_frame", int'(pulses < N), 1);
            chk("x_orig", int'(x_orig), pulses % L);
            chk("y_orig", int'(y_orig), pulses / L);
            chk("pixel_out", int'(pixel_out), (pulses + 16) % 256);
            pulses++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            erro_at_done = int'(erro);
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [2:0] e, output int sc);
        start  = 1'b1;
        escala = e;
        sc     = cyc;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, input int rnd, input logic [2:0] exp_esc);
        for (int k = 0; k < limit; k++) begin
            if (done_cnt > d0) break;
            if (busy) chk("escala_out_hold", int'(escala_out), int'(exp_esc));
            if (rnd != 0) begin
                ready_in = ($urandom_range(0, 3) != 0);
                start    = ($urandom_range(0, 7) == 0);
                escala   = 3'($urandom_range(0, 7));
            end
            tick();
        end
        start    = 1'b0;
        ready_in = 1'b1;
        chk("done_within_bound", int'(done_cnt > d0), 1);
    endtask

    task automatic frame(input logic [2:0] e, input int rnd);
        int sc, d0;
        pulses   = 0;
        d0       = done_cnt;
        ready_in = 1'b1;
        pulse_start(e, sc);
        wait_done(d0, 600, rnd, e);
        $display("[TB] frame escala=%0d rnd=%0d: %0d pulses, done after %0d cycles", e, rnd, pulses, done_cyc - sc);
        chk("pulse_count", pulses, N);
        chk("single_done", done_cnt, d0 + 1);
        chk("escala_out", int'(escala_out), int'(e));
        chk("erro_clear", erro_at_done, 0);
        chk("busy_after_done", int'(busy), 0);
        if (rnd == 0) chk("done_latency", done_cyc - sc, 3 * N + 1);
    endtask

    task automatic check_zero(input string ctx);
        $display("[TB] reset check (%s)", ctx);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_pixel_out", int'(pixel_out), 0);
        chk("rst_x_orig", int'(x_orig), 0);
        chk("rst_y_orig", int'(y_orig), 0);
        chk("rst_escala_out", int'(escala_out), 0);
        chk("rst_enable_out", int'(enable_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_erro", int'(erro), 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, d0, got;

        ready_in = 1'b1;
        repeat (3) tick();
        check_zero("power-on");
        rst = 1'b1;
        repeat (2) tick();

        // Full frame with continuous ready, fixed latency
        frame(3'd2, 0);

        // Random backpressure, spurious starts and escala changes mid-frame
        for (int f = 0; f < 3; f++) frame(3'($urandom_range(1, 7)), 1);

        // Stall five cycles in ENVIA at pixel (1,0)
        pulses = 0;
        d0 = done_cnt;
        ready_in = 1'b1;
        pulse_start(3'd2, sc);
        for (int k = 0; k < 10 && pulses < 1; k++) tick();
        chk("stall_first_pulse", pulses, 1);
        ready_in = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            $display("[TB] stall cycle %0d: enable=%0d x=%0d y=%0d", k, enable_out, x_orig, y_orig);
            chk("stall_enable", int'(enable_out), 0);
            chk("stall_x", int'(x_orig), 1);
            chk("stall_y", int'(y_orig), 0);
            chk("stall_pixel", int'(pixel_out), 8'h11);
            tick();
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk("stall_release_enable", int'(enable_out), 1);
        tick();
        wait_done(d0, 100, 0, 3'd2);
        chk("stall_pulse_count", pulses, N);

        // escala = 0 is rejected immediately with erro
        pulses = 0;
        d0 = done_cnt;
        pulse_start(3'd0, sc);
        wait_done(d0, 10, 0, 3'd0);
        $display("[TB] escala=0: done after %0d cycles, erro=%0d, pulses=%0d", done_cyc - sc, erro_at_done, pulses);
        chk("err_done_latency", done_cyc - sc, 1);
        chk("err_erro_at_done", erro_at_done, 1);
        chk("err_pulses", pulses, 0);
        repeat (2) tick();
        chk("err_erro_sticky", int'(erro), 1);
        chk("err_busy", int'(busy), 0);

        // Next accepted start clears erro
        frame(3'd4, 0);

        // Reset in the middle of a frame
        pulses = 0;
        d0 = done_cnt;
        pulse_start(3'd3, sc);
        for (int k = 0; k < 60 && pulses < 6; k++) tick();
        got = pulses;
        chk("rst_reached_pixel6", got, 6);
        rst = 1'b0;
        #1;
        check_zero("mid-frame");
        repeat (2) tick();
        check_zero("held");
        rst = 1'b1;
        repeat (10) tick();
        chk("rst_no_done", done_cnt, d0);
        chk("rst_no_more_pulses", pulses, got);
        frame(3'd5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
